// File: rtl/exception_control_unit.sv
// exception_control_unit
//
// Responds to the Control_Unit exception interface. When a fault is seen in
// IDLE it arbitrates the cause, saves PC-4 for EPC, reads the handler address
// byte from a fixed memory vector and loads it (zero-extended) into PC.
// Exception_Signal stays high for the whole sequence so the Control_Unit
// idles until Exc_Done.
//
// Ports:
//   Clock            in   system clock, rising edge
//   Reset            in   asynchronous active-low reset
//   OPCode_Error     in   undecoded opcode/funct (never gated)
//   AllowException   in   qualifies Overflow / Div_Zero
//   Overflow         in   ALU signed overflow
//   Div_Zero         in   divider divisor == 0
//   PC               in   current PC (already +4 past the faulting instruction)
//   Mem_Byte         in   memory read data [7:0]
//   Exception_Signal out  exception sequence in progress
//   Exc_Cause        out  00 none, 01 opcode, 10 overflow, 11 div-zero
//   EPC_Value        out  PC-4, data for EPC
//   EPC_Write        out  EPC load enable
//   Exc_Mem_Sel      out  route Exc_Vector onto the memory address (read)
//   Exc_Vector       out  handler vector byte address
//   Exc_Handler_PC   out  {24'b0, Mem_Byte}
//   Exc_PC_Load      out  PC load enable with Exc_Handler_PC
//   Exc_Done         out  one-cycle completion pulse
module exception_control_unit #(
  parameter int          MEM_WAIT     = 2,
  parameter logic [31:0] VEC_OPCODE   = 32'd253,
  parameter logic [31:0] VEC_OVERFLOW = 32'd254,
  parameter logic [31:0] VEC_DIVZERO  = 32'd255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        OPCode_Error,
  input  logic        AllowException,
  input  logic        Overflow,
  input  logic        Div_Zero,
  input  logic [31:0] PC,
  input  logic [7:0]  Mem_Byte,
  output logic        Exception_Signal,
  output logic [1:0]  Exc_Cause,
  output logic [31:0] EPC_Value,
  output logic        EPC_Write,
  output logic        Exc_Mem_Sel,
  output logic [31:0] Exc_Vector,
  output logic [31:0] Exc_Handler_PC,
  output logic        Exc_PC_Load,
  output logic        Exc_Done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SAVE     = 3'd1;
  localparam logic [2:0] MEM_READ = 3'd2;
  localparam logic [2:0] LOAD_PC  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_DIVZERO  = 2'b11;

  // Counter starts at MEM_WAIT-1 so MEM_READ lasts exactly MEM_WAIT cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_WAIT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [3:0]  cnt;
  logic        trigger;
  logic [1:0]  cause_sel;
  logic [31:0] vector_sel;

  assign trigger = OPCode_Error | (AllowException & (Div_Zero | Overflow));

  // Priority: opcode error, then divide by zero, then overflow.
  always_comb begin
    cause_sel  = CAUSE_OVERFLOW;
    vector_sel = VEC_OVERFLOW;
    if (OPCode_Error) begin
      cause_sel  = CAUSE_OPCODE;
      vector_sel = VEC_OPCODE;
    end else if (Div_Zero) begin
      cause_sel  = CAUSE_DIVZERO;
      vector_sel = VEC_DIVZERO;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (trigger) state_nxt = SAVE;
      SAVE:     state_nxt = MEM_READ;
      MEM_READ: if (cnt == 4'd0) state_nxt = LOAD_PC;
      LOAD_PC:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so every output
  // is a flop and each strobe lines up with the cycle its state is active.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      Exception_Signal <= 1'b0;
      Exc_Cause        <= 2'b00;
      EPC_Value        <= 32'd0;
      EPC_Write        <= 1'b0;
      Exc_Mem_Sel      <= 1'b0;
      Exc_Vector       <= 32'd0;
      Exc_Handler_PC   <= 32'd0;
      Exc_PC_Load      <= 1'b0;
      Exc_Done         <= 1'b0;
    end else begin
      state            <= state_nxt;
      Exception_Signal <= (state_nxt != IDLE);
      EPC_Write        <= (state_nxt == SAVE);
      Exc_Mem_Sel      <= (state_nxt == MEM_READ);
      Exc_PC_Load      <= (state_nxt == LOAD_PC);
      Exc_Done         <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (trigger) begin
            Exc_Cause  <= cause_sel;
            Exc_Vector <= vector_sel;
            EPC_Value  <= PC - 32'd4;
          end
        end
        SAVE: cnt <= CNT_LOAD;
        MEM_READ: begin
          // Address has been stable MEM_WAIT cycles; the data byte is valid.
          if (cnt == 4'd0) Exc_Handler_PC <= {24'b0, Mem_Byte};
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_control_unit.sv
module tb_exception_control_unit;
  localparam int MW = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        OPCode_Error, AllowException, Overflow, Div_Zero;
  logic [31:0] PC;
  logic [7:0]  Mem_Byte;
  logic        Exception_Signal, EPC_Write, Exc_Mem_Sel, Exc_PC_Load, Exc_Done;
  logic [1:0]  Exc_Cause;
  logic [31:0] EPC_Value, Exc_Vector, Exc_Handler_PC;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [31:0] hpc;
  } exp_t;
  exp_t sb[$];

  always #5 Clock = ~Clock;

  exception_control_unit #(
    .MEM_WAIT(MW), .VEC_OPCODE(32'd253), .VEC_OVERFLOW(32'd254), .VEC_DIVZERO(32'd255)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .OPCode_Error(OPCode_Error), .AllowException(AllowException),
    .Overflow(Overflow), .Div_Zero(Div_Zero), .PC(PC), .Mem_Byte(Mem_Byte),
    .Exception_Signal(Exception_Signal), .Exc_Cause(Exc_Cause),
    .EPC_Value(EPC_Value), .EPC_Write(EPC_Write), .Exc_Mem_Sel(Exc_Mem_Sel),
    .Exc_Vector(Exc_Vector), .Exc_Handler_PC(Exc_Handler_PC),
    .Exc_PC_Load(Exc_PC_Load), .Exc_Done(Exc_Done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk1({tag, "_sig"},  Exception_Signal, 1'b0);
    chk1({tag, "_wr"},   EPC_Write,        1'b0);
    chk1({tag, "_sel"},  Exc_Mem_Sel,      1'b0);
    chk1({tag, "_load"}, Exc_PC_Load,      1'b0);
    chk1({tag, "_done"}, Exc_Done,         1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_idle(tag);
    chk32({tag, "_cause"}, 32'(Exc_Cause), 32'd0);
    chk32({tag, "_epc"},   EPC_Value,      32'd0);
    chk32({tag, "_vec"},   Exc_Vector,     32'd0);
    chk32({tag, "_hpc"},   Exc_Handler_PC, 32'd0);
  endtask

  task automatic clear_triggers();
    OPCode_Error = 1'b0; Overflow = 1'b0; Div_Zero = 1'b0; AllowException = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] c, input logic [31:0] v,
                          input logic [31:0] e, input logic [31:0] h);
    exp_t x;
    x.cause = c; x.vec = v; x.epc = e; x.hpc = h;
    sb.push_back(x);
  endtask

  // Trigger inputs are already driven; walk the sequence cycle by cycle.
  // inject_at >= 0 pulses OPCode_Error for one cycle at that sequence index.
  task automatic run_seq(input string tag, input int inject_at);
    exp_t e;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i <= MW + 3; i++) begin
      @(posedge Clock); #1;
      if (i == 0) clear_triggers();
      if (i == inject_at) OPCode_Error = 1'b1;
      else if (i == inject_at + 1) OPCode_Error = 1'b0;
      chk1({tag, "_sig"},  Exception_Signal, i < MW + 3);
      chk1({tag, "_wr"},   EPC_Write,        i == 0);
      chk1({tag, "_sel"},  Exc_Mem_Sel,      i >= 1 && i <= MW);
      chk1({tag, "_load"}, Exc_PC_Load,      i == MW + 1);
      chk1({tag, "_done"}, Exc_Done,         i == MW + 2);
      chk32({tag, "_cause"}, 32'(Exc_Cause), 32'(e.cause));
      chk32({tag, "_vec"},   Exc_Vector,     e.vec);
      chk32({tag, "_epc"},   EPC_Value,      e.epc);
      if (i >= MW + 1) chk32({tag, "_hpc"}, Exc_Handler_PC, e.hpc);
    end
  endtask

  initial begin
    Reset = 1'b0; clear_triggers(); PC = 32'd0; Mem_Byte = 8'd0;
    #1;
    check_zero("reset");
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check_zero("post_reset");

    // Basic opcode error
    PC = 32'h10; Mem_Byte = 8'h40; OPCode_Error = 1'b1;
    push_exp(2'b01, 32'd253, 32'hC, 32'h40);
    run_seq("opcode", -1);

    // Overflow without AllowException is ignored
    PC = 32'h100; Mem_Byte = 8'h22; Overflow = 1'b1; AllowException = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      check_idle("ovf_gated");
      chk32("ovf_gated_cause", 32'(Exc_Cause), 32'd1);
    end
    AllowException = 1'b1;
    push_exp(2'b10, 32'd254, 32'hFC, 32'h22);
    run_seq("ovf", -1);

    // All three: opcode wins
    PC = 32'h200; Mem_Byte = 8'h33;
    OPCode_Error = 1'b1; Overflow = 1'b1; Div_Zero = 1'b1; AllowException = 1'b1;
    push_exp(2'b01, 32'd253, 32'h1FC, 32'h33);
    run_seq("prio_all", -1);

    // Div_Zero beats Overflow
    PC = 32'h300; Mem_Byte = 8'h44;
    Overflow = 1'b1; Div_Zero = 1'b1; AllowException = 1'b1;
    push_exp(2'b11, 32'd255, 32'h2FC, 32'h44);
    run_seq("prio_dz", -1);

    // PC=0 wraps, handler byte zero-extended
    PC = 32'h0; Mem_Byte = 8'hFF; Div_Zero = 1'b1; AllowException = 1'b1;
    push_exp(2'b11, 32'd255, 32'hFFFFFFFC, 32'h000000FF);
    run_seq("wrap", -1);

    // Second trigger during MEM_READ is ignored
    PC = 32'h400; Mem_Byte = 8'h55; OPCode_Error = 1'b1;
    push_exp(2'b01, 32'd253, 32'h3FC, 32'h55);
    run_seq("inj_mem", 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check_idle("inj_mem_after");
    end

    // Trigger during DONE is ignored
    PC = 32'h500; Mem_Byte = 8'h66; OPCode_Error = 1'b1;
    push_exp(2'b01, 32'd253, 32'h4FC, 32'h66);
    run_seq("inj_done", MW + 2);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      check_idle("inj_done_after");
    end

    // Trigger in the first IDLE cycle after DONE starts a new sequence
    PC = 32'h600; Mem_Byte = 8'h77; Div_Zero = 1'b1; AllowException = 1'b1;
    push_exp(2'b11, 32'd255, 32'h5FC, 32'h77);
    run_seq("b2b_a", -1);
    PC = 32'h700; Mem_Byte = 8'h88; OPCode_Error = 1'b1;
    push_exp(2'b01, 32'd253, 32'h6FC, 32'h88);
    run_seq("b2b_b", -1);

    // Asynchronous reset in the middle of MEM_READ
    PC = 32'h800; Mem_Byte = 8'h99; OPCode_Error = 1'b1;
    @(posedge Clock); #1;
    clear_triggers();
    chk1("rst_mid_save", EPC_Write, 1'b1);
    @(posedge Clock); #1;
    chk1("rst_mid_memsel", Exc_Mem_Sel, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check_zero("rst_hold");
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    check_idle("rst_release");
    PC = 32'h900; Mem_Byte = 8'hAA; Overflow = 1'b1; AllowException = 1'b1;
    push_exp(2'b10, 32'd254, 32'h8FC, 32'hAA);
    run_seq("after_rst", -1);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
